// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, FSM states and response codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  // Stores only exist in B/H/W flavours; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    unique case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: load extract with sign/zero extension, and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = word[{byte_off[1], 4'b0000} +: 16];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'h0;
    endcase

    store_word = word;
    case (funct3)
      F3_B:    store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-wide data memory; sub-word stores run as read-modify-write.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       resp_rdata_q;
  logic [1:0]        resp_err_q;

  logic              misalign;
  logic              out_of_range;
  logic [1:0]        req_err;
  logic [31:0]       word_addr;
  logic [31:0]       word_src;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  always_comb begin
    misalign = !f3_legal(req_we, req_funct3) ||
               (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    out_of_range = 64'(req_addr) >= 64'(MEM_BYTES);
    if (misalign) begin
      req_err = ERR_MISALIGN;
    end else if (out_of_range) begin
      req_err = ERR_RANGE;
    end else begin
      req_err = ERR_OK;
    end
  end

  always_comb begin
    word_addr      = 32'(addr_q);
    word_addr[1:0] = 2'b00;
  end

  // In RD the load result is formed straight from the memory word so the response
  // register is ready when RESP begins; WR merges against the captured copy.
  assign word_src = (state_q == StRd) ? mem_rdata : rdata_q;

  lsu_lane_align u_lane_align (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .word       (word_src),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign mem_re     = (state_q == StRd);
  assign mem_we     = (state_q == StWr);
  assign mem_addr   = (mem_re || mem_we) ? word_addr : 32'h0;
  assign mem_wdata  = mem_we ? store_word : 32'h0;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= ERR_OK;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_err != ERR_OK) begin
              resp_err_q   <= req_err;
              resp_rdata_q <= 32'h0;
              state_q      <= StResp;
            end else if (!req_we || req_funct3 != F3_W) begin
              state_q <= StRd;
            end else begin
              state_q <= StWr;
            end
          end
        end
        StRd: begin
          rdata_q <= mem_rdata;
          if (we_q) begin
            state_q <= StWr;
          end else begin
            resp_rdata_q <= load_data;
            resp_err_q   <= ERR_OK;
            state_q      <= StResp;
          end
        end
        StWr: begin
          resp_rdata_q <= 32'h0;
          resp_err_q   <= ERR_OK;
          state_q      <= StResp;
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: byte-array reference model, directed plan plus random traffic.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_mem_ctrl #(
    .MEM_BYTES (4096),
    .ADDR_W    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory seen by the DUT; preload port used only while in reset.
  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  assign mem_rdata = (mem_addr < 32'd4096) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we && mem_addr < 32'd4096) mem[mem_addr[11:2]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          due;
    int          nr;
    int          nw;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [0:4095];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_cyc = -1;
  int         due_cyc = -1;
  int         we_cnt = 0;
  int         re_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, little-endian assembly.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int          size;
    bit          legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e.rdata = 32'h0;
    e.nr    = 0;
    e.nw    = 0;
    if (!legal || (a % size) != 0) begin
      e.err = 2'b01;
      e.due = cyc + 1;
    end else if (a >= 32'd4096) begin
      e.err = 2'b10;
      e.due = cyc + 1;
    end else begin
      e.err = 2'b00;
      if (we) begin
        for (int k = 0; k < size; k++) ref_mem[a + k] = wd[8*k +: 8];
        e.nw  = 1;
        e.nr  = (size < 4) ? 1 : 0;
        e.due = cyc + ((size < 4) ? 3 : 2);
      end else begin
        v = 32'h0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = ref_mem[a + k];
        if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
        e.nr    = 1;
        e.due   = cyc + 2;
      end
    end
  endtask

  // Called at a negedge; leaves req_valid high so successive calls run back-to-back.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int   n = 0;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=req_ready 0 required=1 (cycle %0d)", cyc);
      req_valid = 1'b0;
      return;
    end
    model(we, f3, addr, wd, e);
    acc_cyc = cyc;
    due_cyc = e.due;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = 10'(idx);
    pre_data = data;
    for (int k = 0; k < 4; k++) ref_mem[4*idx + k] = data[8*k +: 8];
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'h0);
    @(negedge clk);
  endtask

  // Monitor: ready window, mem strobe exclusivity and per-response strobe counts.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      we_cnt = 0;
      re_cnt = 0;
    end else begin
      chk("req_ready", 32'(req_ready), (cyc > acc_cyc && cyc <= due_cyc) ? 32'h0 : 32'h1);
      chk("we_re_exclusive", 32'(mem_we & mem_re), 32'h0);
      we_cnt += int'(mem_we);
      re_cnt += int'(mem_re);
      if (resp_valid) begin
        chk("resp_expected", 32'(sbq.size() > 0), 32'h1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", 32'(cyc), 32'(e.due));
          chk("mem_re_count", 32'(re_cnt), 32'(e.nr));
          chk("mem_we_count", 32'(we_cnt), 32'(e.nw));
        end
        we_cnt = 0;
        re_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  lf [8];
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          we;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pre_we     = 1'b0;
    pre_idx    = 10'h0;
    pre_data   = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) preload(i, $urandom);
    preload(0, 32'h8877_66F5);
    preload(1, 32'h8000_1234);
    preload(2, 32'hAABB_CCDD);
    preload(3, 32'h1111_1111);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // Directed plan, issued back-to-back with req_valid held high.
    issue(1'b0, F3_B,  32'h1, 32'h0);
    issue(1'b0, F3_B,  32'h0, 32'h0);
    issue(1'b0, F3_BU, 32'h0, 32'h0);
    issue(1'b0, F3_H,  32'h6, 32'h0);
    issue(1'b0, F3_HU, 32'h6, 32'h0);
    issue(1'b0, F3_W,  32'h4, 32'h0);
    issue(1'b1, F3_B,  32'hA, 32'h0000_0011);
    issue(1'b0, F3_W,  32'h8, 32'h0);
    issue(1'b1, F3_H,  32'h8, 32'h0000_5566);
    issue(1'b0, F3_W,  32'h8, 32'h0);
    issue(1'b0, F3_W,  32'h2, 32'h0);
    issue(1'b1, F3_W,  32'h1000, 32'h1234_5678);
    issue(1'b0, F3_W,  32'h1000, 32'h0);
    issue(1'b1, F3_W,  32'h0, 32'hDEAD_BEEF);
    issue(1'b0, F3_W,  32'h0, 32'h0);
    drain();
    chk("sb_sh_merge_word", mem[2], 32'hAA11_5566);
    chk("sw_word", mem[0], 32'hDEAD_BEEF);

    // Reset while an SB sits in RD: nothing may be written.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'hC;
    req_wdata  = 32'h0000_00AB;
    chk("ready_before_abort", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("abort_in_rd", 32'(mem_re), 32'h1);
    rst_n = 1'b0;
    #1;
    req_valid = 1'b0;
    acc_cyc   = -1;
    due_cyc   = -1;
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    chk("abort_resp_rdata", resp_rdata, 32'h0);
    chk("abort_resp_err", 32'(resp_err), 32'h0);
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_mem_re", 32'(mem_re), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem3_kept", mem[3], 32'h1111_1111);
    issue(1'b0, F3_W, 32'hC, 32'h0);
    drain();

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(1));
      f3 = we ? (($urandom_range(9) == 0) ? 3'd7 : 3'($urandom_range(2))) : lf[$urandom_range(7)];
      case ($urandom_range(9))
        0:       addr = $urandom;
        1:       addr = 32'h1000 + 32'($urandom_range(255));
        default: addr = 32'($urandom_range(4095));
      endcase
      if ($urandom_range(3) != 0) addr[1:0] = 2'b00;
      issue(we, f3, addr, $urandom);
      if ($urandom_range(3) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
      end
    end
    drain();

    for (int i = 0; i < 1024; i++) begin
      chk("mem_final", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the word-organised data memory port (mem_we/mem_re/addr/wdata/rdata) on behalf of the core's memory stage. Accepts RV32I load/store requests over a valid/ready handshake. Performs byte-lane extraction with sign/zero extension for loads. Implements sub-word stores (SB/SH) as a read-modify-write, because the memory only writes whole words. Flags misaligned and out-of-range accesses without touching memory.

Parameters:
MEM_BYTES, 4096, size of the data memory in bytes; addresses >= MEM_BYTES are access faults
ADDR_W, 32, width of the request address

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low-order bytes significant for SB/SH)
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  extended load data (0 for stores and faults)
resp_err  out  2  00 ok, 01 misaligned, 10 out of range
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_addr  out  32  word-aligned address (bits [1:0] = 0)
mem_wdata  out  32  full word written
mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=1 after release. resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0. All latched request registers are cleared.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we, funct3, addr and wdata. Then classify the request:
  - misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) -> RESP with err=01.
  - addr >= MEM_BYTES -> RESP with err=10. Misaligned takes priority over out of range.
  - load, or SB/SH -> RD.
  - SW -> WR.
- RD: mem_re=1 and mem_addr={addr[31:2],2'b00}. Capture mem_rdata into rdata_q at the clock edge. Load -> RESP. SB/SH -> WR.
- WR: mem_we=1. mem_wdata is a merge:
  - SW: wdata.
  - SB: rdata_q with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: rdata_q with halfword lane addr[1] replaced by wdata[15:0].
  Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. There is no response backpressure; the pipeline must consume it.
- Load extraction from rdata_q:
  - B/BU select byte addr[1:0]; H/HU select halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - Unsupported funct3 (011, 110, 111) -> err=01 (treated as misaligned/illegal) with no memory access.
- mem_we and mem_re are decoded from the state register only. There is no combinational path from req_* to mem_*. mem_we and mem_re are never high together.
- Latency, counted from the accept edge to resp_valid high:
  - fault: 1 cycle
  - SW: 2 cycles
  - loads: 2 cycles
  - SB/SH: 3 cycles
- req_valid while busy is ignored (req_ready=0). The requester must hold the request until it is accepted.
- Reset asserted in RD or WR: abort immediately. A write is committed only if the WR-state clock edge occurs with rst_n=1.
- resp_rdata and resp_err are held until the next RESP and are valid only when resp_valid=1.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state encoding
  - resp_err codes (ERR_OK, ERR_MISALIGN, ERR_RANGE)
- One natural sub-module: lsu_lane_align. It is combinational and contains the load extract/extend and store merge logic, given funct3, addr[1:0], word and wdata. It is reused by a future cache port.

Test Plan:
- Preload mem[0]=0x8877_66F5. LB @0x1 -> resp_rdata=0xFFFF_FF66? No: byte1=0x66, so the result is 0x0000_0066. LB @0x0 -> 0xFFFF_FFF5. LBU @0x0 -> 0x0000_00F5. Each resp_valid arrives 2 cycles after accept.
- mem[1]=0x8000_1234. LH @0x6 -> 0xFFFF_8000. LHU @0x6 -> 0x0000_8000. LW @0x4 -> 0x8000_1234.
- mem[2]=0xAABB_CCDD. SB @0xA with wdata=0x0000_0011 -> 3-cycle RMW, mem[2]=0xAA11_CCDD. Then SH @0x8 with wdata=0x5566 -> mem[2]=0xAA11_5566. mem_we pulses exactly once per store.
- LW @0x2 -> resp_err=01, resp_valid 1 cycle after accept, mem_re/mem_we never asserted. SW @0x1000 (MEM_BYTES=4096) -> resp_err=10 and memory is unchanged.
- Back-to-back: req_valid held high with SW @0x0 =0xDEAD_BEEF followed by LW @0x0 -> the second request is accepted only after RESP, and the LW returns 0xDEAD_BEEF. Check req_ready=0 in RD/WR/RESP.
- Reset pulse during the RD state of an SB @0xC (mem[3]=0x1111_1111) -> FSM goes to IDLE, all outputs 0, mem[3] stays 0x1111_1111, and a new LW @0xC then returns 0x1111_1111.
